// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle datapath: Moore decode of the current state
// drives every datapath enable. The FSM stalls on MemReady and counts retired instructions.
module multicycle_main_control #(
    parameter int opcodeWidth = 7,
    parameter int aluOpWidth  = 2,
    parameter int retireWidth = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [opcodeWidth-1:0] Opcode,
    input  logic                   Zero,
    input  logic                   MemReady,
    output logic                   PCWrite,
    output logic                   PCWriteCond,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   MemtoReg,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic                   PCSource,
    output logic [aluOpWidth-1:0]  ALUOp,
    output logic                   Illegal,
    output logic [retireWidth-1:0] Retired
);

    localparam logic [opcodeWidth-1:0] OP_RTYPE  = opcodeWidth'(7'b0110011);
    localparam logic [opcodeWidth-1:0] OP_LOAD   = opcodeWidth'(7'b0000011);
    localparam logic [opcodeWidth-1:0] OP_STORE  = opcodeWidth'(7'b0100011);
    localparam logic [opcodeWidth-1:0] OP_BRANCH = opcodeWidth'(7'b1100011);

    localparam logic [aluOpWidth-1:0] ALU_ADD = '0;
    localparam logic [aluOpWidth-1:0] ALU_SUB = aluOpWidth'(2'b01);
    localparam logic [aluOpWidth-1:0] ALU_FN  = aluOpWidth'(2'b10);

    typedef enum logic [3:0] {
        S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXEC, S_RTYPEWB, S_BRANCH, S_TRAP
    } state_e;

    state_e                 state_q, state_d;
    logic                   illegal_q;
    logic [retireWidth-1:0] retired_q;
    logic                   retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_START;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP) illegal_q <= 1'b1;
            if (retire) retired_q <= retired_q + retireWidth'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 1'b0;
        ALUOp       = ALU_ADD;
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALU speculatively forms the branch target into ALUOut
                ALUSrcB = 2'b10;
                if (Opcode == OP_RTYPE)                           state_d = S_EXEC;
                else if (Opcode == OP_LOAD || Opcode == OP_STORE) state_d = S_MEMADR;
                else if (Opcode == OP_BRANCH)                     state_d = S_BRANCH;
                else                                              state_d = S_TRAP;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FN;
                state_d = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                // Zero is consumed by the PC logic through PCWriteCond
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_START;
        endcase
    end

    assign Illegal = illegal_q;
    assign Retired = retired_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Randomised bench for multicycle_main_control: an instruction-level sequence model
// predicts every output each cycle, plus directed literal checks from the test plan.
module tb_multicycle_main_control;

    localparam logic [6:0] OP_R = 7'b0110011, OP_L = 7'b0000011,
                           OP_S = 7'b0100011, OP_B = 7'b1100011;

    // model phase names
    localparam int M_START = 0, M_FETCH = 1, M_DEC = 2, M_MADR = 3, M_MRD = 4,
                   M_MWB = 5, M_MWR = 6, M_EXEC = 7, M_RWB = 8, M_BR = 9, M_TRAP = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] Opcode = OP_R;
    logic Zero = 1'b0, MemReady = 1'b1;
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite;
    logic ALUSrcA, PCSource, Illegal, s_PCWrite, s_PCWriteCond, s_IorD, s_MemRead;
    logic s_MemWrite, s_IRWrite, s_MemtoReg, s_RegWrite, s_ALUSrcA, s_PCSource, s_Illegal;
    logic [1:0] ALUSrcB, ALUOp, s_ALUSrcB, s_ALUOp;
    logic [31:0] Retired;
    logic [3:0]  s_Retired;

    multicycle_main_control dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
        .Illegal(Illegal), .Retired(Retired)
    );

    // narrow counter instance exercises wraparound in a short run
    multicycle_main_control #(.retireWidth(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(s_PCWrite), .PCWriteCond(s_PCWriteCond), .IorD(s_IorD), .MemRead(s_MemRead),
        .MemWrite(s_MemWrite), .IRWrite(s_IRWrite), .MemtoReg(s_MemtoReg), .RegWrite(s_RegWrite),
        .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB), .PCSource(s_PCSource), .ALUOp(s_ALUOp),
        .Illegal(s_Illegal), .Retired(s_Retired)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int rdcnt = 0, wrcnt = 0;
    logic zsel = 1'b0;

    wire [13:0] act_v = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                         RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp};
    wire [13:0] act_s = {s_PCWrite, s_PCWriteCond, s_IorD, s_MemRead, s_MemWrite, s_IRWrite,
                         s_MemtoReg, s_RegWrite, s_ALUSrcA, s_ALUSrcB, s_PCSource, s_ALUOp};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       m_cur = M_START;
    int       m_rest[$];
    logic [31:0] m_ret = '0;
    logic     m_ill = 1'b0;

    function automatic logic [13:0] exp_out(input int ph, input logic mr);
        logic pw, pwc, iord, mrd, mwr, irw, m2r, rw, sa, pcs;
        logic [1:0] sb, op;
        {pw, pwc, iord, mrd, mwr, irw, m2r, rw, sa, pcs} = '0;
        sb = 2'b00; op = 2'b00;
        case (ph)
            M_FETCH: begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            M_DEC:   sb = 2'b10;
            M_MADR:  begin sa = 1; sb = 2'b10; end
            M_MRD:   begin mrd = 1; iord = 1; end
            M_MWB:   begin rw = 1; m2r = 1; end
            M_MWR:   begin mwr = 1; iord = 1; end
            M_EXEC:  begin sa = 1; op = 2'b10; end
            M_RWB:   rw = 1;
            M_BR:    begin sa = 1; op = 2'b01; pwc = 1; pcs = 1; end
            default: ;
        endcase
        return {pw, pwc, iord, mrd, mwr, irw, m2r, rw, sa, sb, pcs, op};
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cur = M_START; m_rest.delete(); m_ret = '0; m_ill = 1'b0;
        end else if (m_cur == M_START) m_cur = M_FETCH;
        else if (m_cur == M_FETCH) begin
            if (MemReady) m_cur = M_DEC;
        end else if (m_cur == M_DEC) begin
            if (Opcode == OP_R)      m_rest = '{M_EXEC, M_RWB};
            else if (Opcode == OP_L) m_rest = '{M_MADR, M_MRD, M_MWB};
            else if (Opcode == OP_S) m_rest = '{M_MADR, M_MWR};
            else if (Opcode == OP_B) m_rest = '{M_BR};
            else                     m_rest = '{M_TRAP};
            m_cur = m_rest.pop_front();
            if (m_cur == M_TRAP) m_ill = 1'b1;
        end else if (m_cur == M_TRAP) m_cur = M_TRAP;
        else if ((m_cur == M_MRD || m_cur == M_MWR) && !MemReady) m_cur = m_cur;
        else if (m_rest.size() == 0) begin
            m_ret = m_ret + 1; m_cur = M_FETCH;
        end else m_cur = m_rest.pop_front();
    end

    always @(negedge clk) begin
        chk("outputs", {50'd0, act_v}, {50'd0, exp_out(m_cur, MemReady)});
        chk("outputs_small", {50'd0, act_s}, {50'd0, exp_out(m_cur, MemReady)});
        chk("illegal", {63'd0, Illegal}, {63'd0, m_ill});
        chk("retired", {32'd0, Retired}, {32'd0, m_ret});
        chk("retired_small", {60'd0, s_Retired}, {60'd0, m_ret[3:0]});
        if (MemRead && IorD) rdcnt++;
        if (MemWrite) wrcnt++;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic mr);
        @(posedge clk); #1;
        MemReady = mr; Zero = zsel;
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        while (m_cur != p && n < 60) begin cyc(1'b1); n++; end
        if (m_cur != p) chk("wait_phase_timeout", 64'(m_cur), 64'(p));
    endtask

    task automatic run_instr(input logic [6:0] op);
        Opcode = op; MemReady = 1'b1;
        cyc(1'b1);
        wait_phase(M_FETCH);
    endtask

    function automatic logic [6:0] pick_op();
        logic [6:0] ops[4];
        ops = '{OP_R, OP_L, OP_S, OP_B};
        if ($urandom_range(0, 19) == 0) return 7'($urandom);
        return ops[$urandom_range(0, 3)];
    endfunction

    initial begin
        int trapc;
        // reset, then R-type
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {50'd0, act_v}, 64'd0);
        chk("reset_retired", {32'd0, Retired}, 64'd0);
        chk("reset_illegal", {63'd0, Illegal}, 64'd0);
        rst_n = 1'b1;
        repeat (3) cyc(1'b1);
        chk("exec_aluop", {62'd0, ALUOp}, 64'd2);
        repeat (2) cyc(1'b1);
        chk("rtype_retired", {32'd0, Retired}, 64'd1);

        // load with 3 stall cycles in MEMRD
        Opcode = OP_L; rdcnt = 0;
        wait_phase(M_MRD);
        MemReady = 1'b0;
        cyc(1'b0); cyc(1'b0); cyc(1'b1);
        wait_phase(M_FETCH);
        chk("load_memrd_cycles", 64'(rdcnt), 64'd4);
        chk("load_retired", {32'd0, Retired}, 64'd2);

        // store
        wrcnt = 0;
        run_instr(OP_S);
        chk("store_memwrite_cycles", 64'(wrcnt), 64'd1);
        chk("store_retired", {32'd0, Retired}, 64'd3);

        // branch, not taken then taken
        zsel = 1'b0; run_instr(OP_B);
        zsel = 1'b1; run_instr(OP_B);
        chk("branch_retired", {32'd0, Retired}, 64'd5);

        // illegal opcode
        Opcode = 7'h7F;
        wait_phase(M_TRAP);
        repeat (20) cyc(1'($urandom));
        chk("trap_illegal", {63'd0, Illegal}, 64'd1);
        chk("trap_outputs", {50'd0, act_v}, 64'd0);
        #2 rst_n = 1'b0;
        #1 chk("reset_clears_illegal", {63'd0, Illegal}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // fetch stall
        Opcode = OP_R;
        repeat (5) cyc(1'b0);
        chk("fetch_stall_irwrite", {62'd0, IRWrite, PCWrite}, 64'd0);
        chk("fetch_stall_memread", {63'd0, MemRead}, 64'd1);

        // randomized traffic with occasional async resets
        trapc = 0;
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 3) != 0);
            zsel = 1'($urandom);
            if (m_cur == M_FETCH || m_cur == M_START) Opcode = pick_op();
            trapc = (m_cur == M_TRAP) ? trapc + 1 : 0;
            if (trapc > 6 || $urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
                trapc = 0;
            end
        end
        chk("random_retired_nonzero", 64'(m_ret != 0 && Retired == m_ret), 64'd1);

        // reset during a MEMWR wait
        wait_phase(M_FETCH);
        Opcode = OP_S;
        wait_phase(M_MWR);
        MemReady = 1'b0;
        cyc(1'b0);
        #2;
        chk("memwr_wait_active", {63'd0, MemWrite}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("memwr_dropped", {63'd0, MemWrite}, 64'd0);
        chk("midstore_reset_outputs", {50'd0, act_v}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) cyc(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multi-cycle datapath. It sits directly upstream of the ALU control block.
- Decodes the 7-bit opcode of the latched instruction. Sequences fetch, decode, execute, memory and writeback.
- Drives all datapath enables, including the 2-bit ALUOp that the ALU control block consumes.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
- opcodeWidth, 7, width of the Opcode input.
- aluOpWidth, 2, width of the ALUOp output.
- retireWidth, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Opcode  input  opcodeWidth  instruction[6:0] taken from the instruction register.
- Zero  input  1  ALU zero flag, sampled only in BRANCH.
- MemReady  input  1  memory has completed the current read or write.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by Zero.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  register writeback select: 0 = ALUOut, 1 = MDR.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  0 = PC, 1 = regA.
- ALUSrcB  output  2  00 = regB, 01 = constant 4, 10 = immediate.
- PCSource  output  1  0 = ALU result, 1 = ALUOut (branch target).
- ALUOp  output  aluOpWidth  00 = add, 01 = subtract, 10 = decode by funct.
- Illegal  output  1  sticky flag: an illegal opcode was decoded.
- Retired  output  retireWidth  count of completed instructions.

Behaviour:
- Reset: asynchronous, active low. While rst_n = 0:
  - state = START;
  - every control output = 0, ALUSrcB = 00, ALUOp = 00;
  - Illegal = 0, Retired = 0.
- The state register updates on the rising clk edge. Control outputs are a Moore decode of state only. Any output not listed for a state is 0.
- START: all outputs 0. Next state is FETCH, unconditionally.
- FETCH:
  - MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00.
  - IRWrite = MemReady and PCWrite = MemReady; PCSource = 0.
  - Stays in FETCH while MemReady = 0; goes to DECODE when MemReady = 1.
- DECODE:
  - ALUSrcA = 0, ALUSrcB = 10, ALUOp = 00 (branch target computed into ALUOut).
  - Next state by Opcode:
    - 0110011 -> EXEC;
    - 0000011 or 0100011 -> MEMADR;
    - 1100011 -> BRANCH;
    - any other value -> TRAP.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next state is MEMRD for a load, MEMWR for a store.
- MEMRD: MemRead = 1, IorD = 1. Waits for MemReady = 1, then goes to MEMWB.
- MEMWB: RegWrite = 1, MemtoReg = 1. Next state is FETCH; the instruction retires.
- MEMWR: MemWrite = 1, IorD = 1. Waits for MemReady = 1, then goes to FETCH; the instruction retires on that edge.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next state is RTYPEWB.
- RTYPEWB: RegWrite = 1, MemtoReg = 0. Next state is FETCH; the instruction retires.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 1. Next state is FETCH; the instruction retires whether or not the branch is taken.
- TRAP: all outputs 0. Illegal is set to 1 on entry. TRAP is absorbing and is left only by reset.
- Retired increments by 1 on each edge that leaves MEMWB, RTYPEWB, BRANCH, or MEMWR (with MemReady = 1). It wraps from all-ones to 0 with no flag.
- MemRead and MemWrite are held constant for the whole wait. A memory request is never withdrawn before MemReady.
- MemReady is ignored in every state that does not wait on it.
- Opcode is sampled only in DECODE and MEMADR. It must stay stable from the end of FETCH until the instruction retires; IRWrite is 0 throughout that window.
- Reset asserted mid-instruction or mid-wait returns to START immediately. An in-flight MemWrite is dropped in the same delta.
- Instruction latency with MemReady held at 1: R-type 4 cycles, load 5, store 4, branch 3 (FETCH through the retire state).

Test Plan:
- Reset, then R-type: hold rst_n = 0, then release with Opcode = 0110011 and MemReady = 1.
  - States: START -> FETCH -> DECODE -> EXEC -> RTYPEWB -> FETCH.
  - ALUOp = 10 in EXEC; RegWrite = 1 only in RTYPEWB; Retired = 1.
- Load with stall: Opcode = 0000011, MemReady = 0 for 3 cycles in MEMRD.
  - MemRead = 1 and IorD = 1 stay held for 4 cycles.
  - MEMWB asserts MemtoReg = 1 and RegWrite = 1; Retired increments once.
- Store: Opcode = 0100011, MemReady = 1.
  - MemWrite = 1 for exactly 1 cycle; RegWrite is never 1; Retired = +1.
- Branch: Opcode = 1100011.
  - BRANCH asserts ALUOp = 01, PCWriteCond = 1, PCSource = 1, for both Zero = 0 and Zero = 1.
  - Retired increments in both cases.
- Illegal opcode and fetch stall:
  - Opcode = 1111111 goes DECODE -> TRAP; Illegal = 1; outputs stay 0 for 20 cycles.
  - rst_n pulse returns to START with Illegal = 0.
  - FETCH with MemReady = 0 keeps IRWrite = 0 and PCWrite = 0.
- Retired wrap and reset mid-store:
  - Preload Retired = all-ones (force) and retire one instruction: Retired = 0.
  - rst_n low during a MEMWR wait: MemWrite drops to 0 asynchronously and state = START.
